// File: rtl/counter_mod_k_ctrl.sv
// counter_mod_k_ctrl: accepts (k, periods) jobs and sequences one modulo-k counter
// through LOAD/RUN, pulsing a tick per period and a done pulse at the end.
module counter_mod_k_ctrl #(
    parameter int N = 2,
    parameter int P = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_valid,
    input  logic [N-1:0] i_k,
    input  logic [P-1:0] i_periods,
    output logic         o_ready,
    input  logic         i_abort,
    output logic         o_ctr_reset,
    output logic [N-1:0] o_ctr_k,
    input  logic [N-1:0] i_ctr_count,
    output logic         o_tick,
    output logic         o_done,
    output logic         o_aborted,
    output logic         o_busy
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    state_t state, state_n;
    logic [N-1:0] k_q, k_n;
    logic [P-1:0] rem_q, rem_n;
    logic ab_q, ab_n;
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
            k_q   <= '0;
            rem_q <= '0;
            ab_q  <= 1'b0;
        end else begin
            state <= state_n;
            k_q   <= k_n;
            rem_q <= rem_n;
            ab_q  <= ab_n;
        end
    end
    always_comb begin
        state_n = state;
        k_n     = k_q;
        rem_n   = rem_q;
        ab_n    = ab_q;
        // k_q is never zero in RUN; the guard keeps k-1 from wrapping regardless
        o_tick  = (state == RUN) && (k_q != '0) && (i_ctr_count == k_q - N'(1));
        unique case (state)
            IDLE: if (i_valid) begin
                k_n     = i_k;
                rem_n   = i_periods;
                ab_n    = (i_k == '0) || (i_periods == '0);
                state_n = ab_n ? DONE : LOAD;
            end
            LOAD: begin
                ab_n    = i_abort;
                state_n = i_abort ? DONE : RUN;
            end
            RUN: if (i_abort) begin
                ab_n    = 1'b1;
                state_n = DONE;
            end else if (o_tick) begin
                rem_n   = rem_q - P'(1);
                state_n = (rem_q == P'(1)) ? DONE : RUN;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    assign o_ready     = (state == IDLE);
    assign o_busy      = (state == LOAD) || (state == RUN);
    assign o_ctr_reset = (state != RUN);
    assign o_ctr_k     = k_q;
    assign o_done      = (state == DONE);
    assign o_aborted   = (state == DONE) && ab_q;
endmodule

// File: tb/tb_counter_mod_k_ctrl.sv
// tb_counter_mod_k_ctrl: directed and random jobs against a timeline model
// derived from job parameters, with a behavioural modulo-k counter attached.
module tb_counter_mod_k_ctrl;
    localparam int N = 2;
    localparam int P = 4;
    logic clk = 1'b0;
    logic rst, valid, abort, ctr_reset, ready, tick, done, aborted, busy;
    logic [N-1:0] k_in, ctr_k, cnt;
    logic [P-1:0] periods;
    logic [7:0] st;
    int n_checks = 0;
    int n_fail = 0;
    int last_k = 0;

    always #5 clk = ~clk;

    counter_mod_k_ctrl #(.N(N), .P(P)) dut (
        .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_k(k_in), .i_periods(periods),
        .o_ready(ready), .i_abort(abort), .o_ctr_reset(ctr_reset), .o_ctr_k(ctr_k),
        .i_ctr_count(cnt), .o_tick(tick), .o_done(done), .o_aborted(aborted), .o_busy(busy)
    );

    always_ff @(posedge clk)
        cnt <= (ctr_reset || ctr_k == '0) ? '0 : N'((int'(cnt) + 1) % int'(ctr_k));

    assign st = {ready, busy, ctr_reset, ctr_k, tick, done, aborted};

    function automatic logic [7:0] mk(bit r, bit b, bit cr, int kk, bit t, bit d, bit a);
        logic [1:0] kv;
        kv = 2'(kk);
        return {r, b, cr, kv, t, d, a};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b (rdy,busy,crst,k[1:0],tick,done,ab)", tag, obs, exp);
        end
    endtask

    // abort_j / reset_j: RUN-cycle index (0-based) in which the pulse is driven, -1 for none
    task automatic run_job(input int k, input int p, input int abort_j, input int reset_j);
        bit rej;
        int fin;
        @(negedge clk);
        check("idle", st, mk(1, 0, 1, last_k, 0, 0, 0));
        valid = 1'b1;
        k_in = N'(k);
        periods = P'(p);
        @(posedge clk);
        last_k = k;
        rej = (k == 0) || (p == 0);
        fin = rej ? 0 : reset_j >= 0 ? reset_j + 2 : abort_j >= 0 ? abort_j + 2 : k * p + 1;
        for (int t = 0; t <= fin; t++) begin
            @(negedge clk);
            if (t == 0) begin
                valid = 1'b0;
                k_in = N'($urandom);
                periods = P'($urandom);
            end
            if (reset_j >= 0 && t == reset_j + 2) begin
                check("reset_mid", st, mk(1, 0, 1, 0, 0, 0, 0));
                last_k = 0;
                rst = 1'b0;
                return;
            end
            if (t == fin) check("done", st, mk(0, 0, 1, k, 0, 1, rej || abort_j >= 0));
            else if (t == 0) check("load", st, mk(0, 1, 1, k, 0, 0, 0));
            else check("run", st, mk(0, 1, 0, k, ((t - 1) % k) == k - 1, 0, 0));
            abort = (abort_j >= 0) && (t == abort_j + 1);
            rst = (reset_j >= 0) && (t == reset_j + 1);
        end
        abort = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        valid = 1'b0;
        abort = 1'b0;
        k_in = '0;
        periods = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("in_reset", st, mk(1, 0, 1, 0, 0, 0, 0));
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("idle_after_reset", st, mk(1, 0, 1, 0, 0, 0, 0));
        end
        run_job(3, 2, -1, -1);
        run_job(1, 3, -1, -1);
        run_job(0, 2, -1, -1);
        run_job(2, 0, -1, -1);
        run_job(3, 4, 3, -1);
        run_job(2, 1, 1, -1);
        run_job(3, 2, -1, 2);
        run_job(2, 1, -1, -1);
        // valid raised during DONE must wait for IDLE before being accepted
        run_job(3, 2, -1, -1);
        valid = 1'b1;
        k_in = 2'd2;
        periods = 4'd1;
        @(negedge clk);
        check("b2b_idle", st, mk(1, 0, 1, 3, 0, 0, 0));
        @(negedge clk);
        check("b2b_load", st, mk(0, 1, 1, 2, 0, 0, 0));
        valid = 1'b0;
        @(negedge clk);
        check("b2b_run0", st, mk(0, 1, 0, 2, 0, 0, 0));
        @(negedge clk);
        check("b2b_run1", st, mk(0, 1, 0, 2, 1, 0, 0));
        @(negedge clk);
        check("b2b_done", st, mk(0, 0, 1, 2, 0, 1, 0));
        last_k = 2;
        for (int i = 0; i < 25; i++) begin
            int k, p, a, r;
            k = $urandom_range(0, 3);
            p = $urandom_range(0, 15);
            a = -1;
            r = -1;
            if (k * p > 0) begin
                if ($urandom_range(0, 3) == 0) a = $urandom_range(0, k * p - 1);
                else if ($urandom_range(0, 7) == 0) r = $urandom_range(0, k * p - 1);
            end
            run_job(k, p, a, r);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
